dac_dwa_driver: RTL and testbench
=================================

DAC_DWA_DRIVER -- requirements
Module: dac_dwa_driver

Interface
REQ-001 The block SHALL have parameter DEAD_CYC, default 2: break-before-make idle cycles on a polarity change, legal range 1..15.
REQ-002 The block SHALL have parameter ROTATE, default 1: 1 selects data-weighted-averaging cell rotation, 0 selects fixed thermometer mapping.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: drive enable.
REQ-006 The block SHALL have port sine_in, input, 33 bits: thermometer magnitude from the sine generator, bit 0 filled first.
REQ-007 The block SHALL have port sign, input, 1 bit: 1 = positive half-cycle.
REQ-008 The block SHALL have port signB, input, 1 bit: complement of sign.
REQ-009 The block SHALL have port cell_en, output, 33 bits: unit current-cell enables.
REQ-010 The block SHALL have port pos_en, output, 1 bit: positive H-bridge leg enable.
REQ-011 The block SHALL have port neg_en, output, 1 bit: negative H-bridge leg enable.
REQ-012 The block SHALL have port level, output, 6 bits: registered magnitude, 0..33.
REQ-013 The block SHALL have port code_err, output, 1 bit: one-cycle pulse on an illegal thermometer code.

Function
REQ-014 Stage 1 SHALL register sine_in, sign and signB, then decode level = number of ones when the code is a contiguous run starting at bit 0.
REQ-015 On a non-thermometer code, level SHALL hold its previous value and code_err SHALL pulse high for exactly one cycle.
REQ-016 Stage 2 SHALL produce cell_en; latency from sine_in to cell_en SHALL be 2 cycles.
REQ-017 With ROTATE=1, cell_en SHALL enable level cells starting at index ptr, wrapping modulo 33.
REQ-018 With ROTATE=1, ptr SHALL update to (ptr+level) mod 33 on each cycle in which cells are driven.
REQ-019 Level 0 SHALL give cell_en=0; level 33 SHALL give all ones; in both cases ptr SHALL be left unchanged.
REQ-020 With ROTATE=0, cell_en SHALL equal the registered thermometer code and ptr SHALL stay 0.
REQ-021 The polarity FSM SHALL have states OFF, DEAD, POS and NEG; only POS drives pos_en and only NEG drives neg_en.
REQ-022 In OFF and DEAD, cell_en, pos_en and neg_en SHALL all be 0 and ptr SHALL hold.
REQ-023 In OFF with en=1 and a valid sign (sign != signB), the FSM SHALL go to DEAD with target = registered sign.
REQ-024 In POS, a registered sign of 0 SHALL cause DEAD with target NEG; in NEG, a registered sign of 1 SHALL cause DEAD with target POS.
REQ-025 DEAD SHALL last exactly DEAD_CYC cycles and then enter the target state.
REQ-026 A sign toggle during DEAD SHALL retarget and restart the count.
REQ-027 From any state, en=0 or sign==signB (registered) SHALL force OFF on the next edge; invalid sign takes priority over a pending polarity change.
REQ-028 pos_en and neg_en SHALL never be high in the same cycle.
REQ-029 pos_en, neg_en and cell_en SHALL be registered outputs, glitch-free.

Reset
REQ-030 On rst=1 at a clock edge: FSM = OFF, ptr = 0, level = 0, cell_en = 0, pos_en = 0, neg_en = 0, code_err = 0, and pipeline registers cleared.
REQ-031 Reset asserted mid-operation SHALL take effect on the same edge regardless of state or DEAD count.
REQ-032 After release, the first drive SHALL occur no earlier than DEAD_CYC+1 cycles after en=1 with a valid sign.

Verification
REQ-033 Bench SHALL cover: reset, en=1, sign=1/signB=0, sine_in=0x7 constant -> pos_en=1 after DEAD; cell_en successively 0x7, 0x38, 0x1C0; level=3.
REQ-034 Bench SHALL cover: ptr=31, level=5 -> cell_en bits 31,32,0,1,2 set; next ptr=3.
REQ-035 Bench SHALL cover: sign 1->0 while in POS -> exactly 2 cycles with pos_en=neg_en=cell_en=0, then neg_en=1; never both legs high.
REQ-036 Bench SHALL cover: sine_in=0x5 after level=3 -> code_err high 1 cycle; level stays 3.
REQ-037 Bench SHALL cover: sign=signB=1 during NEG -> OFF next cycle, all outputs 0; and rst during DEAD -> OFF, ptr=0.
REQ-038 Bench SHALL cover: ROTATE=0 with sine_in=0x1FFFFFFFF -> cell_en all ones, level=33, ptr stays 0.

Source files
------------

// File: rtl/dac_dwa_driver.sv
// Thermometer-to-current-cell driver with DWA rotation and break-before-make H-bridge polarity control.
// Latency sine_in -> cell_en is 2 cycles; no backpressure, a new code is accepted every cycle.
module dac_dwa_driver #(
    parameter int unsigned DEAD_CYC = 2,
    parameter bit          ROTATE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [32:0] sine_in,
    input  logic        sign,
    input  logic        signB,
    output logic [32:0] cell_en,
    output logic        pos_en,
    output logic        neg_en,
    output logic [5:0]  level,
    output logic        code_err
);

    typedef enum logic [1:0] {OFF, DEAD, POS, NEG} state_t;

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC - 1);

    logic [32:0] therm_q;
    logic        sign_q, signb_q;
    logic [5:0]  level_q, level_d;
    logic        code_err_q, code_err_d;
    logic [32:0] cell_en_q, cell_en_d;
    logic        pos_en_q, pos_en_d;
    logic        neg_en_q, neg_en_d;
    logic [5:0]  ptr_q, ptr_d;
    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic [3:0]  dead_cnt_q, dead_cnt_d;

    logic [33:0] therm_inc;
    logic        code_ok;
    logic [5:0]  ones;
    logic        sign_ok;
    logic        drive;
    logic [32:0] base;
    logic [65:0] dbl;
    logic [6:0]  ptr_sum;

    // A contiguous run from bit 0 is exactly a code whose increment shares no set bits with it.
    always_comb begin
        therm_inc = {1'b0, therm_q} + 34'd1;
        code_ok   = (({1'b0, therm_q} & therm_inc) == 34'd0);
        ones      = 6'd0;
        for (int i = 0; i < 33; i++) begin
            ones = ones + {5'd0, therm_q[i]};
        end
        level_d    = code_ok ? ones : level_q;
        code_err_d = ~code_ok;
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        dead_cnt_d = dead_cnt_q;
        sign_ok    = sign_q ^ signb_q;
        if (!en || !sign_ok) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    state_d    = DEAD;
                    tgt_d      = sign_q;
                    dead_cnt_d = DEAD_LOAD;
                end
                DEAD: begin
                    if (sign_q != tgt_q) begin
                        tgt_d      = sign_q;
                        dead_cnt_d = DEAD_LOAD;
                    end else if (dead_cnt_q == 4'd0) begin
                        state_d = tgt_q ? POS : NEG;
                    end else begin
                        dead_cnt_d = dead_cnt_q - 4'd1;
                    end
                end
                POS: begin
                    if (!sign_q) begin
                        state_d    = DEAD;
                        tgt_d      = 1'b0;
                        dead_cnt_d = DEAD_LOAD;
                    end
                end
                NEG: begin
                    if (sign_q) begin
                        state_d    = DEAD;
                        tgt_d      = 1'b1;
                        dead_cnt_d = DEAD_LOAD;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Outputs are derived from the next state so the registered legs and cells switch together.
    always_comb begin
        drive    = (state_d == POS) || (state_d == NEG);
        pos_en_d = (state_d == POS);
        neg_en_d = (state_d == NEG);
        base     = ~({33{1'b1}} << level_d);
        dbl      = {base, base} << ptr_q;
        ptr_sum  = {1'b0, ptr_q} + {1'b0, level_d};
        if (ROTATE) begin
            cell_en_d = drive ? dbl[65:33] : 33'd0;
            ptr_d     = ptr_q;
            if (drive && level_d != 6'd0 && level_d != 6'd33) begin
                ptr_d = (ptr_sum >= 7'd33) ? 6'(ptr_sum - 7'd33) : ptr_sum[5:0];
            end
        end else begin
            cell_en_d = drive ? base : 33'd0;
            ptr_d     = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            therm_q    <= 33'd0;
            sign_q     <= 1'b0;
            signb_q    <= 1'b0;
            level_q    <= 6'd0;
            code_err_q <= 1'b0;
            cell_en_q  <= 33'd0;
            pos_en_q   <= 1'b0;
            neg_en_q   <= 1'b0;
            ptr_q      <= 6'd0;
            state_q    <= OFF;
            tgt_q      <= 1'b0;
            dead_cnt_q <= 4'd0;
        end else begin
            therm_q    <= sine_in;
            sign_q     <= sign;
            signb_q    <= signB;
            level_q    <= level_d;
            code_err_q <= code_err_d;
            cell_en_q  <= cell_en_d;
            pos_en_q   <= pos_en_d;
            neg_en_q   <= neg_en_d;
            ptr_q      <= ptr_d;
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign cell_en  = cell_en_q;
    assign pos_en   = pos_en_q;
    assign neg_en   = neg_en_q;
    assign level    = level_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_dac_dwa_driver.sv
// Directed bench for dac_dwa_driver: one rotating instance and one fixed-mapping instance share stimulus.
module tb_dac_dwa_driver;

    logic        clk = 1'b0;
    logic        rst, en, sign, signB;
    logic [32:0] sine_in;
    logic [32:0] cell_en, cell_en_f;
    logic        pos_en, neg_en, pos_en_f, neg_en_f;
    logic [5:0]  level, level_f;
    logic        code_err, code_err_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_dwa_driver #(.DEAD_CYC(2), .ROTATE(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .sine_in(sine_in), .sign(sign), .signB(signB),
        .cell_en(cell_en), .pos_en(pos_en), .neg_en(neg_en), .level(level), .code_err(code_err)
    );

    dac_dwa_driver #(.DEAD_CYC(2), .ROTATE(1'b0)) dut_fix (
        .clk(clk), .rst(rst), .en(en), .sine_in(sine_in), .sign(sign), .signB(signB),
        .cell_en(cell_en_f), .pos_en(pos_en_f), .neg_en(neg_en_f), .level(level_f), .code_err(code_err_f)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sign = 1'b0; signB = 1'b0; sine_in = 33'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cell_en !== 33'd0 || pos_en !== 1'b0 || neg_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got cell_en=%h pos=%b neg=%b, expected all 0", cell_en, pos_en, neg_en);
        end
        checks++;
        if (level !== 6'd0 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_level: got level=%0d code_err=%b, expected 0/0", level, code_err);
        end
        checks++;
        if (cell_en_f !== 33'd0 || pos_en_f !== 1'b0 || level_f !== 6'd0) begin
            errors++;
            $display("FAIL reset_fixed: got cell_en=%h pos=%b level=%0d, expected 0", cell_en_f, pos_en_f, level_f);
        end
    endtask

    task automatic test_basic();
        logic [32:0] exp_cells [3];
        exp_cells[0] = 33'h7; exp_cells[1] = 33'h38; exp_cells[2] = 33'h1C0;
        do_reset();
        en = 1'b1; sign = 1'b1; signB = 1'b0; sine_in = 33'h7;
        tick();
        tick();
        checks++;
        if (level !== 6'd3 || pos_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_level: got level=%0d pos=%b, expected 3/0", level, pos_en);
        end
        tick();
        checks++;
        if (pos_en !== 1'b0 || cell_en !== 33'd0) begin
            errors++;
            $display("FAIL basic_dead: got pos=%b cell_en=%h, expected 0/0", pos_en, cell_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cell_en !== exp_cells[i] || pos_en !== 1'b1 || neg_en !== 1'b0) begin
                errors++;
                $display("FAIL basic_rot%0d: got cell_en=%h pos=%b neg=%b, expected %h/1/0",
                         i, cell_en, pos_en, neg_en, exp_cells[i]);
            end
            checks++;
            if (cell_en_f !== 33'h7) begin
                errors++;
                $display("FAIL basic_fixed%0d: got cell_en=%h, expected 7", i, cell_en_f);
            end
        end
    endtask

    task automatic test_wrap();
        logic [32:0] t31;
        t31 = 33'h7FFF_FFFF;
        do_reset();
        en = 1'b1; sign = 1'b1; signB = 1'b0; sine_in = t31;
        tick();
        tick();
        tick();
        sine_in = 33'h1F;
        tick();
        checks++;
        if (cell_en !== 33'h0_7FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_fill31: got cell_en=%h, expected 07fffffff", cell_en);
        end
        tick();
        checks++;
        if (cell_en !== 33'h1_8000_0007) begin
            errors++;
            $display("FAIL wrap_ptr31: got cell_en=%h, expected 180000007", cell_en);
        end
        tick();
        checks++;
        if (cell_en !== 33'hF8) begin
            errors++;
            $display("FAIL wrap_nextptr3: got cell_en=%h, expected f8", cell_en);
        end
    endtask

    task automatic test_polarity();
        logic        exp_pos [4];
        logic        exp_neg [4];
        logic [32:0] exp_cell [4];
        exp_pos  = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_neg  = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_cell = '{33'h38, 33'h0, 33'h0, 33'h1C0};
        do_reset();
        en = 1'b1; sign = 1'b1; signB = 1'b0; sine_in = 33'h7;
        for (int i = 0; i < 4; i++) tick();
        sign = 1'b0; signB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pos_en !== exp_pos[i] || neg_en !== exp_neg[i] || cell_en !== exp_cell[i]) begin
                errors++;
                $display("FAIL polarity_step%0d: got pos=%b neg=%b cell_en=%h, expected %b/%b/%h",
                         i, pos_en, neg_en, cell_en, exp_pos[i], exp_neg[i], exp_cell[i]);
            end
            checks++;
            if ((pos_en & neg_en) !== 1'b0) begin
                errors++;
                $display("FAIL polarity_overlap%0d: got pos=%b neg=%b, expected not both 1", i, pos_en, neg_en);
            end
        end
    endtask

    task automatic test_code_err();
        do_reset();
        en = 1'b1; sign = 1'b1; signB = 1'b0; sine_in = 33'h7;
        for (int i = 0; i < 4; i++) tick();
        sine_in = 33'h5;
        tick();
        checks++;
        if (code_err !== 1'b0 || level !== 6'd3) begin
            errors++;
            $display("FAIL codeerr_before: got code_err=%b level=%0d, expected 0/3", code_err, level);
        end
        sine_in = 33'h7;
        tick();
        checks++;
        if (code_err !== 1'b1 || level !== 6'd3) begin
            errors++;
            $display("FAIL codeerr_pulse: got code_err=%b level=%0d, expected 1/3", code_err, level);
        end
        tick();
        checks++;
        if (code_err !== 1'b0 || level !== 6'd3) begin
            errors++;
            $display("FAIL codeerr_after: got code_err=%b level=%0d, expected 0/3", code_err, level);
        end
    endtask

    task automatic test_off_and_reset();
        do_reset();
        en = 1'b1; sign = 1'b0; signB = 1'b1; sine_in = 33'h7;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (neg_en !== 1'b1 || pos_en !== 1'b0 || cell_en !== 33'h7) begin
            errors++;
            $display("FAIL neg_drive: got neg=%b pos=%b cell_en=%h, expected 1/0/7", neg_en, pos_en, cell_en);
        end
        sign = 1'b1; signB = 1'b1;
        tick();
        tick();
        checks++;
        if (neg_en !== 1'b0 || pos_en !== 1'b0 || cell_en !== 33'd0) begin
            errors++;
            $display("FAIL invalid_off: got neg=%b pos=%b cell_en=%h, expected 0/0/0", neg_en, pos_en, cell_en);
        end
        sign = 1'b1; signB = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (level !== 6'd0 || cell_en !== 33'd0 || pos_en !== 1'b0 || neg_en !== 1'b0) begin
            errors++;
            $display("FAIL dead_reset: got level=%0d cell_en=%h pos=%b neg=%b, expected 0", level, cell_en, pos_en, neg_en);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pos_en !== 1'b0 || cell_en !== 33'd0) begin
                errors++;
                $display("FAIL release_early%0d: got pos=%b cell_en=%h, expected 0/0", i, pos_en, cell_en);
            end
        end
        tick();
        checks++;
        if (pos_en !== 1'b1 || cell_en !== 33'h7) begin
            errors++;
            $display("FAIL release_ptr0: got pos=%b cell_en=%h, expected 1/7", pos_en, cell_en);
        end
    endtask

    task automatic test_full_and_zero();
        do_reset();
        en = 1'b1; sign = 1'b1; signB = 1'b0; sine_in = 33'h1_FFFF_FFFF;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (cell_en_f !== 33'h1_FFFF_FFFF || level_f !== 6'd33 || dut_fix.ptr_q !== 6'd0) begin
            errors++;
            $display("FAIL fixed_full: got cell_en=%h level=%0d ptr=%0d, expected 1ffffffff/33/0",
                     cell_en_f, level_f, dut_fix.ptr_q);
        end
        checks++;
        if (cell_en !== 33'h1_FFFF_FFFF) begin
            errors++;
            $display("FAIL rot_full: got cell_en=%h, expected 1ffffffff", cell_en);
        end
        sine_in = 33'h7;
        tick();
        sine_in = 33'h0;
        tick();
        checks++;
        if (cell_en !== 33'h7 || cell_en_f !== 33'h7 || dut_fix.ptr_q !== 6'd0) begin
            errors++;
            $display("FAIL after_full: got cell_en=%h fixed=%h ptr_f=%0d, expected 7/7/0",
                     cell_en, cell_en_f, dut_fix.ptr_q);
        end
        sine_in = 33'h7;
        tick();
        checks++;
        if (cell_en !== 33'd0 || pos_en !== 1'b1) begin
            errors++;
            $display("FAIL level_zero: got cell_en=%h pos=%b, expected 0/1", cell_en, pos_en);
        end
        tick();
        checks++;
        if (cell_en !== 33'h38) begin
            errors++;
            $display("FAIL after_zero: got cell_en=%h, expected 38", cell_en);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sign = 1'b0; signB = 1'b0; sine_in = 33'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_polarity();
        test_code_err();
        test_off_and_reset();
        test_full_and_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
